// File: rtl/midi_pkg.sv
// Shared MIDI definitions: register map, status bit positions, baud rate,
// status-byte class ranges and serializer state encoding. Also used by the
// MIDI receive port.
package midi_pkg;

  // Register offsets relative to BASE_ADDR
  localparam logic [7:0] REG_STATUS = 8'd0;
  localparam logic [7:0] REG_DATA   = 8'd1;

  // Status register bit indices
  localparam int STAT_TX_RDY = 0;
  localparam int STAT_BUSY   = 1;
  localparam int STAT_OVF    = 2;

  // Line rate and nominal bus clock (default divider = 1 MHz / 31250 = 32)
  localparam int MIDI_BAUD  = 31250;
  localparam int SYS_CLK_HZ = 1_000_000;

  // Status-byte class ranges
  localparam logic [7:0] CHAN_STATUS_LO = 8'h80;
  localparam logic [7:0] CHAN_STATUS_HI = 8'hEF;
  localparam logic [7:0] SYS_COMMON_LO  = 8'hF0;
  localparam logic [7:0] REALTIME_LO    = 8'hF8;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  function automatic logic is_chan_status(input logic [7:0] b);
    return (b >= CHAN_STATUS_LO) && (b <= CHAN_STATUS_HI);
  endfunction

  // System common / sysex bytes 0xF0..0xF7
  function automatic logic is_sys_common(input logic [7:0] b);
    return (b >= SYS_COMMON_LO) && (b < REALTIME_LO);
  endfunction

endpackage

// File: rtl/midi_tx_if.sv
// 8-bit Wishbone slave bundle for the MIDI transmitter.
interface midi_tx_if;
  logic [7:0] wb_addr_i;
  logic [7:0] wb_dat_i;
  logic [7:0] wb_dat_o;
  logic       wb_stb_i;
  logic       wb_we_i;
  logic       wb_ack_o;

  modport master (
    output wb_addr_i, wb_dat_i, wb_stb_i, wb_we_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_addr_i, wb_dat_i, wb_stb_i, wb_we_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/fifo.sv
// Generic first-word-fall-through FIFO with active-high async reset.
// A write into a full FIFO is refused even if a read happens in the same cycle.
module fifo #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd,
  input  logic          wr,
  input  logic [DW-1:0] data_i,
  output logic [DW-1:0] data_o,
  output logic          empty_n,
  output logic          full_n
);
  localparam logic [AW:0] DEPTH = (AW+1)'(2 ** AW);

  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          wr_ok, rd_ok;

  assign empty_n = (count_reg != '0);
  assign full_n  = (count_reg != DEPTH);
  assign wr_ok   = wr & full_n;
  assign rd_ok   = rd & empty_n;
  assign data_o  = mem[rd_ptr_reg];

  // Storage write port
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_reg] <= data_i;
  end

  // Pointers and occupancy; simultaneous push and pop leave the count unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_ok) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (wr_ok && !rd_ok)      count_reg <= count_reg + 1'b1;
      else if (rd_ok && !wr_ok) count_reg <= count_reg - 1'b1;
    end
  end
endmodule

// File: rtl/midi_tx_uart_tx.sv
// 8N1 UART serializer: baud divider, frame FSM and shift register with a
// byte/valid/ready handshake. The line output is registered, so it trails
// the FSM state by one cycle; every bit still lasts exactly BAUD_DIV cycles.
module uart_tx
  import midi_pkg::*;
#(
  parameter int BAUD_DIV = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_byte,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       line
);
  localparam logic [15:0] BIT_LAST = 16'(BAUD_DIV - 1);

  tx_state_t   state_reg, state_next;
  logic [15:0] bit_cnt_reg;
  logic [2:0]  idx_reg;
  logic [7:0]  shift_reg;
  logic        bit_end, accept, line_next;

  assign bit_end = (bit_cnt_reg == BIT_LAST);
  assign accept  = tx_ready & tx_valid;

  // State register plus divider, data index and shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= TX_IDLE;
      bit_cnt_reg <= '0;
      idx_reg     <= '0;
      shift_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        shift_reg   <= tx_byte;
        idx_reg     <= '0;
        bit_cnt_reg <= '0;
      end else if (state_reg != TX_IDLE) begin
        bit_cnt_reg <= bit_end ? 16'd0 : bit_cnt_reg + 16'd1;
        if (state_reg == TX_DATA && bit_end) begin
          shift_reg <= {1'b0, shift_reg[7:1]};
          idx_reg   <= idx_reg + 3'd1;
        end
      end
    end
  end

  // Next-state logic; STOP chains straight into START when a byte is waiting
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      TX_IDLE:  if (tx_valid) state_next = TX_START;
      TX_START: if (bit_end) state_next = TX_DATA;
      TX_DATA:  if (bit_end && idx_reg == 3'd7) state_next = TX_STOP;
      TX_STOP:  if (bit_end) state_next = tx_valid ? TX_START : TX_IDLE;
      default:  state_next = TX_IDLE;
    endcase
  end

  // Output decode: handshake, busy flag and the line level for this state
  always_comb begin
    tx_ready  = (state_reg == TX_IDLE) || (state_reg == TX_STOP && bit_end);
    busy      = (state_reg != TX_IDLE);
    line_next = 1'b1;
    case (state_reg)
      TX_START: line_next = 1'b0;
      TX_DATA:  line_next = shift_reg[0];
      default:  line_next = 1'b1;
    endcase
  end

  // Registered line driver; reset forces the line idle-high immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) line <= 1'b1;
    else        line <= line_next;
  end
endmodule

// File: rtl/midi_tx.sv
// Wishbone-mapped MIDI OUT transmitter: register file, transmit FIFO,
// optional running-status filter and the UART serializer.
// Optional feature macro: MIDI_TX_RUNNING_STATUS_EN (drop repeated channel
// status bytes that match the last transmitted one).
module midi_tx
  import midi_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'h00,
  parameter int         BAUD_DIV  = SYS_CLK_HZ / MIDI_BAUD,
  parameter int         FIFO_AW   = 4
) (
  input  logic     wb_clk_i,
  input  logic     wb_rst_n_i,
  midi_tx_if.slave bus,
  output logic     midi_out
);
  localparam logic [7:0] STATUS_ADDR = BASE_ADDR + REG_STATUS;
  localparam logic [7:0] DATA_ADDR   = BASE_ADDR + REG_DATA;

  logic       ack_reg, ovf_reg;
  logic [7:0] dat_o_reg, status_word, fifo_q;
  logic       access, push, status_rd;
  logic       fifo_rst, fifo_rd, fifo_empty_n, fifo_full_n;
  logic       drop, uart_valid, uart_ready, uart_busy;

  assign bus.wb_ack_o = ack_reg;
  assign bus.wb_dat_o = dat_o_reg;

  // An access is taken on the edge that raises ack
  assign access    = bus.wb_stb_i & ~ack_reg;
  assign push      = access & bus.wb_we_i & (bus.wb_addr_i == DATA_ADDR);
  assign status_rd = access & ~bus.wb_we_i & (bus.wb_addr_i == STATUS_ADDR);

  // Assemble the status word from the live flags
  always_comb begin
    status_word              = 8'h00;
    status_word[STAT_TX_RDY] = fifo_full_n;
    status_word[STAT_BUSY]   = fifo_empty_n | uart_busy;
    status_word[STAT_OVF]    = ovf_reg;
  end

  // Bus ack/read data and the sticky overflow flag
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      ack_reg   <= 1'b0;
      dat_o_reg <= 8'h00;
      ovf_reg   <= 1'b0;
    end else begin
      ack_reg   <= bus.wb_stb_i & ~ack_reg;
      dat_o_reg <= status_rd ? status_word : 8'h00;
      if (status_rd)                ovf_reg <= 1'b0;
      else if (push && !fifo_full_n) ovf_reg <= 1'b1;
    end
  end

  assign fifo_rst = ~wb_rst_n_i;

  fifo #(
    .DW(8),
    .AW(FIFO_AW)
  ) u_fifo (
    .clk    (wb_clk_i),
    .rst    (fifo_rst),
    .rd     (fifo_rd),
    .wr     (push),
    .data_i (bus.wb_dat_i),
    .data_o (fifo_q),
    .empty_n(fifo_empty_n),
    .full_n (fifo_full_n)
  );

  // The head byte leaves the FIFO whenever the serializer can take a byte;
  // a filtered byte is popped without starting a frame.
  assign fifo_rd    = fifo_empty_n & uart_ready;
  assign uart_valid = fifo_empty_n & ~drop;

`ifdef MIDI_TX_RUNNING_STATUS_EN
  logic [7:0] rs_reg;

  // A value of 0 never matches a channel status byte, so it means "none"
  assign drop = is_chan_status(fifo_q) && (fifo_q == rs_reg);

  // Track the last transmitted channel status; sys common/sysex forgets it
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      rs_reg <= 8'h00;
    end else if (fifo_rd && !drop) begin
      if (is_chan_status(fifo_q))     rs_reg <= fifo_q;
      else if (is_sys_common(fifo_q)) rs_reg <= 8'h00;
    end
  end
`else
  assign drop = 1'b0;
`endif

  uart_tx #(
    .BAUD_DIV(BAUD_DIV)
  ) u_uart (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_n_i),
    .tx_byte (fifo_q),
    .tx_valid(uart_valid),
    .tx_ready(uart_ready),
    .busy    (uart_busy),
    .line    (midi_out)
  );
endmodule

// File: tb/tb_midi_tx.sv
// Scoreboard bench for midi_tx: stimulus pushes expected frame bytes,
// a line monitor decodes each 8N1 frame and compares against the queue.
module tb_midi_tx;
  localparam int BD = 32;
  localparam logic [7:0] A_STAT = 8'h00;
  localparam logic [7:0] A_DATA = 8'h01;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic midi_out;
  int   cyc = 0;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];
  int         starts[$];
  int         frames_seen = 0;
  bit         mon_busy = 1'b0;
  bit         abort_frame = 1'b0;
  int         last_ack_cyc = 0;

  midi_tx_if bus();

  midi_tx #(
    .BASE_ADDR(8'h00),
    .BAUD_DIV (BD),
    .FIFO_AW  (4)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_n_i(rst_n),
    .bus       (bus),
    .midi_out  (midi_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end else begin
      $display("ok   %s = %0h", name, got);
    end
  endtask

  task automatic bus_access(input logic [7:0] a, input logic [7:0] d, input logic we,
                            output logic [7:0] rdata);
    bit got;
    got = 1'b0;
    rdata = 8'h00;
    @(negedge clk);
    bus.wb_addr_i = a;
    bus.wb_dat_i  = d;
    bus.wb_we_i   = we;
    bus.wb_stb_i  = 1'b1;
    for (int k = 0; k < 8 && !got; k++) begin
      @(posedge clk);
      #1;
      if (bus.wb_ack_o) begin
        got = 1'b1;
        rdata = bus.wb_dat_o;
      end
    end
    last_ack_cyc = cyc;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL ack_timeout: addr %02h got no ack, expected ack within 8 cycles", a);
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    logic [7:0] unused_rd;
    bus_access(a, d, 1'b1, unused_rd);
    $display("wr   addr=%02h data=%02h ack@%0d", a, d, last_ack_cyc);
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    bus_access(a, 8'h00, 1'b0, d);
    $display("rd   addr=%02h data=%02h", a, d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    starts.delete();
  endtask

  task automatic drain(input string name, input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || mon_busy) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({name, "_drained"}, {31'd0, (exp_q.size() == 0 && !mon_busy)}, 32'd1);
    repeat (4 * BD) @(negedge clk);
  endtask

  // Line monitor: decode every frame, sample every cycle so bit length and
  // stability are checked as well as the bit values.
  initial begin : monitor
    int s;
    logic [9:0] bits;
    bit glitch;
    logic [7:0] exp;
    forever begin
      @(negedge clk);
      if (rst_n && midi_out === 1'b0) begin
        mon_busy = 1'b1;
        s = cyc;
        starts.push_back(s);
        bits = '0;
        glitch = 1'b0;
        for (int i = 1; i < 10 * BD; i++) begin
          @(negedge clk);
          if (i % BD == 0) bits[i / BD] = midi_out;
          else if (midi_out !== bits[i / BD]) glitch = 1'b1;
        end
        if (abort_frame) begin
          abort_frame = 1'b0;
          $display("frame @%0d abandoned by reset", s);
        end else begin
          frames_seen++;
          n_vec++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_frame @%0d: got byte %02h, expected no frame", s, bits[8:1]);
          end else begin
            exp = exp_q.pop_front();
            if (bits[0] !== 1'b0 || bits[9] !== 1'b1 || glitch || bits[8:1] !== exp) begin
              n_err++;
              $display("FAIL frame @%0d: got start=%b data=%02h stop=%b glitch=%0d, expected 0/%02h/1/0",
                       s, bits[0], bits[8:1], bits[9], glitch, exp);
            end else begin
              $display("frm  @%0d data=%02h", s, bits[8:1]);
            end
          end
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin : stim
    logic [7:0] rd;
    int s;
    int k;
    int fc;

    bus.wb_addr_i = 8'h00;
    bus.wb_dat_i  = 8'h00;
    bus.wb_we_i   = 1'b0;
    bus.wb_stb_i  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ack", {31'd0, bus.wb_ack_o}, 32'd0);
    check("reset_dat_o", {24'd0, bus.wb_dat_o}, 32'h00);
    check("reset_line", {31'd0, midi_out}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state through the bus
    bus_read(A_STAT, rd);
    check("status_after_reset", {24'd0, rd}, 32'h01);
    check("line_idle", {31'd0, midi_out}, 32'd1);
    bus_read(A_DATA, rd);
    check("data_read_zero", {24'd0, rd}, 32'h00);
    bus_read(8'h7F, rd);
    check("other_addr_read_zero", {24'd0, rd}, 32'h00);

    // Single byte: latency and bit pattern
    exp_q.push_back(8'h90);
    bus_write(A_DATA, 8'h90);
    k = last_ack_cyc;
    bus_read(A_STAT, rd);
    check("status_busy", {24'd0, rd}, 32'h03);
    drain("single", 20 * BD);
    check("first_edge_latency", starts.size() > 0 ? starts[0] - k : -1, 32'd2);
    bus_read(A_STAT, rd);
    check("status_idle_again", {24'd0, rd}, 32'h01);

    // Note-on sequence with a repeated status byte
    do_reset();
`ifdef MIDI_TX_RUNNING_STATUS_EN
    exp_q.push_back(8'h90); exp_q.push_back(8'h3C); exp_q.push_back(8'h64);
    exp_q.push_back(8'h3C); exp_q.push_back(8'h00);
`else
    exp_q.push_back(8'h90); exp_q.push_back(8'h3C); exp_q.push_back(8'h64);
    exp_q.push_back(8'h90); exp_q.push_back(8'h3C); exp_q.push_back(8'h00);
`endif
    bus_write(A_DATA, 8'h90);
    bus_write(A_DATA, 8'h3C);
    bus_write(A_DATA, 8'h64);
    bus_write(A_DATA, 8'h90);
    bus_write(A_DATA, 8'h3C);
    bus_write(A_DATA, 8'h00);
    drain("noteon", 80 * BD);
`ifdef MIDI_TX_RUNNING_STATUS_EN
    check("noteon_frames", starts.size(), 32'd5);
`else
    check("noteon_frames", starts.size(), 32'd6);
    if (starts.size() == 6) begin
      for (int i = 1; i < 6; i++)
        check($sformatf("gap_%0d", i), starts[i] - starts[i-1], 10 * BD);
      check("total_cycles", starts[5] - starts[0] + 10 * BD, 60 * BD);
    end
`endif

    // Real-time vs system-common effect on running status
    do_reset();
`ifdef MIDI_TX_RUNNING_STATUS_EN
    exp_q.push_back(8'h90); exp_q.push_back(8'hF8);
    exp_q.push_back(8'hF0); exp_q.push_back(8'h90);
`else
    exp_q.push_back(8'h90); exp_q.push_back(8'hF8); exp_q.push_back(8'h90);
    exp_q.push_back(8'hF0); exp_q.push_back(8'h90);
`endif
    bus_write(A_DATA, 8'h90);
    bus_write(A_DATA, 8'hF8);
    bus_write(A_DATA, 8'h90);
    bus_write(A_DATA, 8'hF0);
    bus_write(A_DATA, 8'h90);
    drain("rtstat", 70 * BD);

    // Overflow: 1 in the shifter + 16 in the FIFO, the 18th is dropped
    do_reset();
    for (int i = 0; i < 18; i++) begin
      if (i < 17) exp_q.push_back(8'(i + 1));
      bus_write(A_DATA, 8'(i + 1));
    end
    bus_read(A_STAT, rd);
    check("status_ovf", {24'd0, rd}, 32'h06);
    bus_read(A_STAT, rd);
    check("status_ovf_cleared", {24'd0, rd}, 32'h02);
    drain("overflow", 190 * BD);

    // Reset during data bit 3 abandons the frame and flushes the FIFO
    do_reset();
    bus_write(A_DATA, 8'h55);
    bus_write(A_DATA, 8'h33);
    k = 0;
    while (starts.size() == 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("abort_frame_started", {31'd0, starts.size() > 0}, 32'd1);
    if (starts.size() > 0) begin
      s = starts[0];
      while (cyc < s + 4 * BD + BD / 2) @(negedge clk);
      check("bit3_before_reset", {31'd0, midi_out}, 32'd0);
      abort_frame = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_line", {31'd0, midi_out}, 32'd1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      fc = frames_seen;
      bus_read(A_STAT, rd);
      check("status_after_abort", {24'd0, rd}, 32'h01);
      repeat (30 * BD) @(negedge clk);
      check("no_frames_after_abort", starts.size(), 32'd1);
      check("frames_count_after_abort", frames_seen, fc);
    end

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
